ifetch: RTL

Instruction fetch stage of the pipelined ucpu, sitting directly upstream of the decode stage and driving the asynchronous instruction ROM (8-bit address, 12-bit word). It owns the program counter, presents the PC to the ROM every cycle, captures the returned word together with its PC into a small instruction queue, and hands entries to decode over a valid/ready handshake. It also handles branch redirects, which flush the queue, and a halt request, which stops fetching.

---
 rtl/ucpu_pkg.sv | 17 +
 rtl/ifetch_queue.sv | 79 +++++++
 rtl/ifetch.sv | 68 ++++++
 3 files changed

// File: rtl/ucpu_pkg.sv
// Shared ucpu types and constants: address/instruction widths and the fetch entry payload.
package ucpu_pkg;

    localparam int unsigned AW = 8;
    localparam int unsigned IW = 12;

    typedef logic [AW-1:0] addr_t;
    typedef logic [IW-1:0] instr_t;

    localparam addr_t RESET_PC = '0;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Small circular FIFO of fetch entries between the PC/ROM side and decode.
module ifetch_queue
    import ucpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_entry,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          valid
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          valid_q;
    logic          full_q;
    logic          pop_ok;
    logic          push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Occupancy is tracked apart from the pointers so full and empty stay distinct.
    always_comb begin
        pop_ok  = pop & valid_q;
        push_ok = push & (~full_q | pop_ok);
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
            full_q  <= (count_d == CW'(DEPTH));
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (push_ok) begin
                    mem[tail_q] <= wr_entry;
                    tail_q      <= ptr_inc(tail_q);
                end
                if (pop_ok) begin
                    head_q <= ptr_inc(head_q);
                end
            end
        end
    end

    assign head  = mem[head_q];
    assign count = count_q;
    assign valid = valid_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register driving the async ROM, redirect/halt control, and the decode-side queue.
module ifetch
    import ucpu_pkg::*;
#(
    parameter int unsigned   AW       = ucpu_pkg::AW,
    parameter int unsigned   IW       = ucpu_pkg::IW,
    parameter int unsigned   DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = ucpu_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_data,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] pc_q;
    logic [CW-1:0] q_count;
    logic          q_valid;
    logic          pop_c;
    logic          push_c;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    assign pop_c  = q_valid & id_ready;
    assign push_c = ~redirect & ~halt & ((q_count < CW'(DEPTH)) | pop_c);

    // Redirect wins over everything; halt simply withholds the push so the PC holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc;
        end else if (push_c) begin
            pc_q <= pc_q + AW'(1);
        end
    end

    assign wr_entry = '{pc: pc_q, instr: rom_data};

    ifetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_c),
        .pop      (pop_c & ~redirect),
        .flush    (redirect),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (q_count),
        .valid    (q_valid)
    );

    assign rom_addr = pc_q;
    assign id_valid = q_valid;
    assign id_pc    = head.pc;
    assign id_instr = head.instr;

endmodule
